darkbus_arbiter: RTL
====================

# darkbus_arbiter

Round-robin arbiter that lets N_PROV darkbus providers (core instruction/data ports, DMA, debug) share one darkbus consumer (RAM, IO bank). It generalises darkbus with parametrised address/data width, split read/write data instead of a tri-state data bus, and an optional watchdog that terminates stuck transactions with an error. It sits between the provider ports and the address decoder / memory.

## Interface
- N_PROV, 4: number of provider ports (2..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width, multiple of 8.
- BE_W, DATA_W/8: byte-enable width (derived, do not override).
- TIMEOUT, 255: watchdog limit in cycles (used only with DARKBUS_TIMEOUT_EN).

- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- p_en  in  N_PROV  request from provider i; held high until its p_valid.
- p_rw  in  N_PROV  1 = write, 0 = read.
- p_be  in  N_PROV*BE_W  byte enables, provider i at slice i.
- p_addr  in  N_PROV*ADDR_W  address per provider.
- p_wdata  in  N_PROV*DATA_W  write data per provider.
- p_valid  out  N_PROV  one-cycle completion pulse to the owner.
- p_err  out  N_PROV  qualifies p_valid: transaction timed out.
- p_rdata  out  DATA_W  read data, shared, valid with p_valid.
- c_en, c_rw, c_be, c_addr, c_wdata  out  1/1/BE_W/ADDR_W/DATA_W  request to consumer.
- c_rdata  in  DATA_W  consumer read data.
- c_valid  in  1  consumer completion, sampled only while c_en=1.
- grant  out  N_PROV  one-hot current owner, 0 when idle.

## Operation
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE: if any p_en, pick first requester at or after ptr (wrapping N_PROV-1 -> 0); latch rw/be/addr/wdata of winner into c_* registers, set grant, go BUSY. No requests: stay.
- BUSY: c_en=1, c_* stable. On c_valid: capture c_rdata into p_rdata, pulse p_valid[owner], c_en=0, go DONE.
- DONE: one cycle; owner drops or re-raises p_en; p_en ignored; ptr <= owner+1 mod N_PROV; grant cleared; go IDLE.
- Provider dropping p_en during BUSY does not abort; transaction completes, p_valid still pulses.
- Writes: p_rdata undefined-but-driven (captures c_rdata anyway).
- Reset (any state, any time): state IDLE, ptr 0, c_en 0, grant 0, p_valid 0, p_err 0, all c_* and p_rdata 0. Consumer must treat c_en falling mid-transaction as abandoned.

## Timing
- All outputs registered.
- Min latency: p_en sampled at edge T0 -> c_en high in cycle T1; zero-wait consumer (c_valid in T1) -> p_valid high in cycle T2.
- Max throughput: one transaction per 3 cycles (IDLE, BUSY, DONE).
- p_valid, p_err: exactly one cycle high, only for owner.
- Fairness: with all providers requesting continuously, each served once every N_PROV transactions.

## Configuration
- DARKBUS_TIMEOUT_EN defined: counter cleared entering BUSY, increments each BUSY cycle; when it reaches TIMEOUT with no c_valid, go DONE with p_valid[owner]=1, p_err[owner]=1, p_rdata all ones, c_en=0. c_valid on the same cycle as expiry wins (normal completion, p_err=0).
- Not defined: no counter; BUSY waits indefinitely; p_err tied 0 (port kept).

## Test plan
- Single read: provider 2 requests addr 0x100, consumer returns 0xCAFEF00D same cycle -> c_en cycle 1, p_valid[2] and p_rdata=0xCAFEF00D cycle 2, p_err=0.
- Contention: providers 0,1,3 request together from reset -> served order 0,1,3; then all four continuous -> order 0,1,2,3,0 (wrap).
- Wait states: consumer delays c_valid 5 cycles on write addr 0x40, be 4'b0011 -> c_* stable for all 6 BUSY cycles, single p_valid pulse.
- Timeout (macro on, TIMEOUT=8): consumer never responds -> p_valid[1]=1, p_err[1]=1, p_rdata=0xFFFFFFFF after 8 BUSY cycles; macro off -> still BUSY after 100 cycles.
- Reset mid-BUSY: rst_n low during wait -> all outputs 0 immediately; after release provider 3 request granted first-come from ptr 0.
- Early drop: provider 0 drops p_en in BUSY -> transaction completes, p_valid[0] still pulses once.

Source files
------------

// File: rtl/darkbus_if.sv
// Darkbus arbiter bundle: per-provider request/response vectors plus the single consumer port.
interface darkbus_if #(
    parameter int unsigned N_PROV = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = DATA_W / 8
);
    logic [N_PROV-1:0]        p_en;
    logic [N_PROV-1:0]        p_rw;
    logic [N_PROV*BE_W-1:0]   p_be;
    logic [N_PROV*ADDR_W-1:0] p_addr;
    logic [N_PROV*DATA_W-1:0] p_wdata;
    logic [N_PROV-1:0]        p_valid;
    logic [N_PROV-1:0]        p_err;
    logic [DATA_W-1:0]        p_rdata;
    logic                     c_en;
    logic                     c_rw;
    logic [BE_W-1:0]          c_be;
    logic [ADDR_W-1:0]        c_addr;
    logic [DATA_W-1:0]        c_wdata;
    logic [DATA_W-1:0]        c_rdata;
    logic                     c_valid;
    logic [N_PROV-1:0]        grant;

    // slave is the arbiter; master is the provider/consumer environment around it
    modport slave (
        input  p_en, p_rw, p_be, p_addr, p_wdata, c_rdata, c_valid,
        output p_valid, p_err, p_rdata, c_en, c_rw, c_be, c_addr, c_wdata, grant
    );
    modport master (
        output p_en, p_rw, p_be, p_addr, p_wdata, c_rdata, c_valid,
        input  p_valid, p_err, p_rdata, c_en, c_rw, c_be, c_addr, c_wdata, grant
    );
endinterface

// File: rtl/darkbus_arbiter.sv
// Round-robin arbiter sharing one darkbus consumer among N_PROV providers.
// Optional watchdog enabled by defining DARKBUS_TIMEOUT_EN.
module darkbus_arbiter #(
    parameter int unsigned N_PROV  = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BE_W    = DATA_W / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input logic      clk,
    input logic      rst_n,
    darkbus_if.slave bus
);
    localparam int unsigned PTR_W = (N_PROV > 1) ? $clog2(N_PROV) : 1;

    if (N_PROV < 2 || N_PROV > 16 || (DATA_W % 8) != 0 || BE_W != DATA_W / 8 || TIMEOUT == 0) begin : g_param_check
        $error("darkbus_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_next;
    logic [PTR_W-1:0]    ptr, ptr_d, owner, owner_d, win;
    logic                win_found;
    logic                expired;
    logic                c_en_d, c_rw_d;
    logic [BE_W-1:0]     c_be_d;
    logic [ADDR_W-1:0]   c_addr_d;
    logic [DATA_W-1:0]   c_wdata_d, p_rdata_d;
    logic [N_PROV-1:0]   grant_d, p_valid_d, p_err_d;

    // First requester at or after ptr, wrapping past the top index
    always_comb begin
        int unsigned cand;
        win       = ptr;
        win_found = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < N_PROV; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N_PROV) cand = cand - N_PROV;
            if (!win_found && bus.p_en[cand]) begin
                win_found = 1'b1;
                win       = PTR_W'(cand);
            end
        end
    end

`ifdef DARKBUS_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    // Counts BUSY cycles; held at zero everywhere else so it restarts on each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             to_cnt <= '0;
        else if (state != BUSY) to_cnt <= '0;
        else                    to_cnt <= to_cnt + TO_W'(1);
    end
    assign expired = (state == BUSY) && (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (win_found) state_next = BUSY;
            BUSY:    if (bus.c_valid || expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of every registered output; c_valid beats a same-cycle expiry
    always_comb begin
        ptr_d     = ptr;
        owner_d   = owner;
        grant_d   = bus.grant;
        c_en_d    = bus.c_en;
        c_rw_d    = bus.c_rw;
        c_be_d    = bus.c_be;
        c_addr_d  = bus.c_addr;
        c_wdata_d = bus.c_wdata;
        p_rdata_d = bus.p_rdata;
        p_valid_d = '0;
        p_err_d   = '0;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    owner_d   = win;
                    grant_d   = N_PROV'(1) << win;
                    c_en_d    = 1'b1;
                    c_rw_d    = bus.p_rw[win];
                    c_be_d    = bus.p_be[32'(win)*BE_W +: BE_W];
                    c_addr_d  = bus.p_addr[32'(win)*ADDR_W +: ADDR_W];
                    c_wdata_d = bus.p_wdata[32'(win)*DATA_W +: DATA_W];
                end
            end
            BUSY: begin
                if (bus.c_valid || expired) begin
                    c_en_d    = 1'b0;
                    p_valid_d = N_PROV'(1) << owner;
                    if (bus.c_valid) begin
                        p_rdata_d = bus.c_rdata;
                    end else begin
                        p_rdata_d = '1;
                        p_err_d   = N_PROV'(1) << owner;
                    end
                end
            end
            DONE: begin
                grant_d = '0;
                ptr_d   = (owner == PTR_W'(N_PROV - 1)) ? '0 : owner + PTR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            owner       <= '0;
            bus.grant   <= '0;
            bus.c_en    <= 1'b0;
            bus.c_rw    <= 1'b0;
            bus.c_be    <= '0;
            bus.c_addr  <= '0;
            bus.c_wdata <= '0;
            bus.p_rdata <= '0;
            bus.p_valid <= '0;
            bus.p_err   <= '0;
        end else begin
            ptr         <= ptr_d;
            owner       <= owner_d;
            bus.grant   <= grant_d;
            bus.c_en    <= c_en_d;
            bus.c_rw    <= c_rw_d;
            bus.c_be    <= c_be_d;
            bus.c_addr  <= c_addr_d;
            bus.c_wdata <= c_wdata_d;
            bus.p_rdata <= p_rdata_d;
            bus.p_valid <= p_valid_d;
            bus.p_err   <= p_err_d;
        end
    end
endmodule
